// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan sequencer: FSM state encoding, the number
// of scanned channels and the width of a channel index.
// ---------------------------------------------------------------------------
package scan_pkg;

    localparam int SCAN_CH    = 4;
    localparam int SCAN_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_sequencer_rr_next.sv
// ---------------------------------------------------------------------------
// rr_next
// Combinational round-robin channel search.
//   mask : per-channel enable, bit i set means channel i may be visited
//   from : channel the search is anchored on
//   incl : 1 = scan from, from+1, from+2, from+3
//          0 = scan from+1, from+2, from+3, from
//   idx  : first enabled channel in scan order (from when none is found)
//   any  : at least one mask bit is set
// ---------------------------------------------------------------------------
module rr_next
    import scan_pkg::*;
(
    input  logic [SCAN_CH-1:0]    mask,
    input  logic [SCAN_IDX_W-1:0] from,
    input  logic                  incl,
    output logic [SCAN_IDX_W-1:0] idx,
    output logic                  any
);

    logic [SCAN_IDX_W-1:0] cand_s;

    // Walk the scan order backwards so the earliest candidate is the last
    // one written; index arithmetic wraps naturally in two bits.
    always_comb begin
        idx    = from;
        any    = 1'b0;
        cand_s = from;
        for (int k = SCAN_CH - 1; k >= 0; k--) begin
            cand_s = from + SCAN_IDX_W'(k) + (incl ? 2'd0 : 2'd1);
            if (mask[cand_s]) begin
                idx = cand_s;
                any = 1'b1;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
// Walks a decoder2to4 {E, A} pair across the enabled channels in round-robin
// order. Each visited channel is enabled for PRESCALE cycles, followed by
// BLANK cycles with the enable low (no gap when BLANK = 0).
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   run        : scan enable, level sensitive
//   mask       : per-channel visit enable
//   sel        : channel index / decoder A (registered)
//   en         : decoder E, high only inside an active slot (registered)
//   slot_start : one-cycle pulse in the first cycle of each slot (registered)
// ---------------------------------------------------------------------------
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [SCAN_CH-1:0]    mask,
    output logic [SCAN_IDX_W-1:0] sel,
    output logic                  en,
    output logic                  slot_start
);

    localparam int MAX_DWELL = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW        = $clog2(MAX_DWELL + 1);
    localparam logic [CW-1:0] ACT_LOAD = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LOAD = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    scan_state_t           state_r, state_s;
    logic [SCAN_IDX_W-1:0] sel_r, sel_s;
    logic                  en_r, en_s;
    logic                  ss_r, ss_s;
    logic [CW-1:0]         cnt_r, cnt_s;

    logic [SCAN_IDX_W-1:0] rr_idx_s;
    logic                  rr_any_s;
    logic                  incl_s;

    // From IDLE the current channel itself is a valid first choice; once
    // scanning, the search starts after the channel just served.
    assign incl_s = (state_r == IDLE);

    rr_next u_rr_next (
        .mask (mask),
        .from (sel_r),
        .incl (incl_s),
        .idx  (rr_idx_s),
        .any  (rr_any_s)
    );

    // Next-state and next-output logic; run has priority over mask.
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        en_s    = en_r;
        ss_s    = 1'b0;
        cnt_s   = (cnt_r != '0) ? (cnt_r - CW'(1)) : '0;

        if (!run) begin
            state_s = IDLE;
            en_s    = 1'b0;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rr_any_s) begin
                        state_s = ACTIVE;
                        sel_s   = rr_idx_s;
                        en_s    = 1'b1;
                        ss_s    = 1'b1;
                        cnt_s   = ACT_LOAD;
                    end else begin
                        en_s    = 1'b0;
                        cnt_s   = '0;
                    end
                end
                ACTIVE: begin
                    if (mask == 4'b0000) begin
                        state_s = IDLE;
                        en_s    = 1'b0;
                        cnt_s   = '0;
                    end else if ((cnt_r == '0) || !mask[sel_r]) begin
                        // Slot over, either by dwell expiry or because its
                        // own channel was masked off.
                        if (BLANK > 0) begin
                            state_s = GAP;
                            en_s    = 1'b0;
                            cnt_s   = GAP_LOAD;
                        end else begin
                            state_s = ACTIVE;
                            sel_s   = rr_idx_s;
                            en_s    = 1'b1;
                            ss_s    = 1'b1;
                            cnt_s   = ACT_LOAD;
                        end
                    end else begin
                        en_s    = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_r == '0) begin
                        // mask is only consulted here, at the gap exit.
                        if (rr_any_s) begin
                            state_s = ACTIVE;
                            sel_s   = rr_idx_s;
                            en_s    = 1'b1;
                            ss_s    = 1'b1;
                            cnt_s   = ACT_LOAD;
                        end else begin
                            state_s = IDLE;
                            en_s    = 1'b0;
                            cnt_s   = '0;
                        end
                    end else begin
                        en_s    = 1'b0;
                    end
                end
                default: begin
                    state_s = IDLE;
                    en_s    = 1'b0;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, dwell counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= '0;
            en_r    <= 1'b0;
            ss_r    <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            en_r    <= en_s;
            ss_r    <= ss_s;
            cnt_r   <= cnt_s;
        end
    end

    assign sel        = sel_r;
    assign en         = en_r;
    assign slot_start = ss_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
// Drives two sequencers (PRESCALE=4 with BLANK=1 and BLANK=0) from shared
// run/mask/rst. A slot-phase reference model produces the expected outputs
// for every edge; they are queued and compared when the outputs settle.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

    localparam int P = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       ss;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, ss_a, ss_b;

    int n_tests;
    int n_fail;

    // Model state per instance: 0 = BLANK 1, 1 = BLANK 0.
    bit         m_act   [2];
    int         m_phase [2];
    logic [1:0] m_sel   [2];

    obs_t q_a[$];
    obs_t q_b[$];

    scan_sequencer #(.PRESCALE(4), .BLANK(1)) dut (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
        .sel(sel_a), .en(en_a), .slot_start(ss_a)
    );

    scan_sequencer #(.PRESCALE(4), .BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
        .sel(sel_b), .en(en_b), .slot_start(ss_b)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] first_from(input logic [3:0] m, input logic [1:0] f, input bit incl);
        logic [1:0] c;
        for (int s = 0; s < 4; s++) begin
            c = f + 2'(s) + (incl ? 2'd0 : 2'd1);
            if (m[c]) return c;
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_phase[i] = 0;
            m_sel[i]   = 2'd0;
        end
    endtask

    task automatic advance(input int i);
        if (mask == 4'b0000) begin
            m_act[i] = 1'b0;
        end else begin
            m_sel[i]   = first_from(mask, m_sel[i], 1'b0);
            m_phase[i] = 0;
        end
    endtask

    // One clock edge of the slot-phase model: phase 0..P-1 is the enabled
    // slot, P..P+blank-1 is the gap.
    task automatic model_step(input int i);
        int bl;
        bl = (i == 0) ? 1 : 0;
        if (!run) begin
            m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
            if (mask != 4'b0000) begin
                m_sel[i]   = first_from(mask, m_sel[i], 1'b1);
                m_phase[i] = 0;
                m_act[i]   = 1'b1;
            end
        end else if (m_phase[i] < P && mask == 4'b0000) begin
            m_act[i] = 1'b0;
        end else if (m_phase[i] < P && !mask[m_sel[i]]) begin
            if (bl > 0) m_phase[i] = P;
            else        advance(i);
        end else begin
            m_phase[i]++;
            if (m_phase[i] >= P + bl) advance(i);
        end
    endtask

    function automatic obs_t model_out(input int i);
        obs_t o;
        o.sel = m_sel[i];
        o.en  = m_act[i] && (m_phase[i] < P);
        o.ss  = m_act[i] && (m_phase[i] == 0);
        return o;
    endfunction

    // Advance one edge: model predicts, prediction is queued, then the
    // settled DUT outputs are compared against the popped prediction.
    task automatic step();
        obs_t e;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
        #1;
        e = q_a.pop_front();
        check_eq("a_sel", {30'd0, sel_a}, {30'd0, e.sel});
        check_eq("a_en",  {31'd0, en_a},  {31'd0, e.en});
        check_eq("a_ss",  {31'd0, ss_a},  {31'd0, e.ss});
        e = q_b.pop_front();
        check_eq("b_sel", {30'd0, sel_b}, {30'd0, e.sel});
        check_eq("b_en",  {31'd0, en_b},  {31'd0, e.en});
        check_eq("b_ss",  {31'd0, ss_b},  {31'd0, e.ss});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until instance 0 is at the given channel and slot phase.
    task automatic wait_slot(input logic [1:0] ch, input int ph, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            if (m_act[0] && m_sel[0] == ch && m_phase[0] == ph) hit = 1'b1;
            else step();
        end
        check_eq(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst  = 1'b1;
        run  = 1'b0;
        mask = 4'b0000;
        #12;
        check_eq("rst_sel", {30'd0, sel_a}, 32'd0);
        check_eq("rst_en",  {31'd0, en_a},  32'd0);
        check_eq("rst_ss",  {31'd0, ss_a},  32'd0);
        steps(2);

        // Full mask, run from reset release.
        rst  = 1'b0;
        run  = 1'b1;
        mask = 4'b1111;
        step();
        check_eq("first_slot_sel", {30'd0, sel_a}, 32'd0);
        check_eq("first_slot_ss",  {31'd0, ss_a},  32'd1);
        steps(22);

        // Alternate channels only.
        run  = 1'b0;
        steps(2);
        mask = 4'b1010;
        run  = 1'b1;
        steps(22);

        // Single channel.
        mask = 4'b0100;
        steps(16);

        // Run dropped in dwell cycle 2 of channel 1, then resumed.
        mask = 4'b1111;
        wait_slot(2'd1, 1, "wait_ch1_dwell2");
        run = 1'b0;
        step();
        check_eq("drop_en",  {31'd0, en_a},  32'd0);
        check_eq("drop_sel", {30'd0, sel_a}, 32'd1);
        steps(3);
        run = 1'b1;
        step();
        check_eq("resume_sel", {30'd0, sel_a}, 32'd1);
        check_eq("resume_en",  {31'd0, en_a},  32'd1);
        steps(4);

        // Asynchronous reset in the middle of channel 2's slot.
        wait_slot(2'd2, 1, "wait_ch2");
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_sel", {30'd0, sel_a}, 32'd0);
        check_eq("async_rst_en",  {31'd0, en_a},  32'd0);
        check_eq("async_rst_ss",  {31'd0, ss_a},  32'd0);
        model_reset();
        steps(2);
        rst = 1'b0;
        step();
        check_eq("restart_sel", {30'd0, sel_a}, 32'd0);
        steps(6);

        // Masking off the channel being served, then everything.
        wait_slot(2'd2, 1, "wait_ch2_mask");
        mask = 4'b1011;
        step();
        check_eq("mask_abort_en", {31'd0, en_a}, 32'd0);
        steps(3);
        mask = 4'b0000;
        steps(4);
        mask = 4'b0001;
        steps(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
